// File: rtl/dma_bus_requester_if.sv
// Signal bundle between the DMA bus requester, its command source, the bus arbiter
// and the read port. The master modport is the requester's view.
interface dma_bus_requester_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              dma_breq;
  logic              dma_grant;
  logic              bus_rd;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              done;
  logic              err;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, dma_grant, bus_ack, bus_rdata,
    output cmd_ready, dma_breq, bus_rd, bus_addr, rd_valid, rd_data, done, err
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, dma_grant, bus_ack, bus_rdata,
    input  cmd_ready, dma_breq, bus_rd, bus_addr, rd_valid, rd_data, done, err
  );
endinterface

// File: rtl/dma_bus_requester.sv
// DMA bus-master front end: requests the bus, reads one word per granted beat,
// pauses and re-requests on grant loss, and aborts if the grant never arrives.
module dma_bus_requester #(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 16,
  parameter int LEN_W         = 8,
  parameter int GRANT_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  dma_bus_requester_if.master bus
);

  localparam logic [15:0] WAIT_LAST = 16'(GRANT_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_REL} state_t;

  state_t            state_q, state_d;
  logic              breq_q, breq_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [15:0]       wait_q, wait_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              bus_rd_w;

  assign bus_rd_w      = (state_q == S_XFER) && bus.dma_grant;
  assign bus.bus_rd    = bus_rd_w;
  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.dma_breq  = breq_q;
  assign bus.bus_addr  = addr_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

  always_comb begin
    state_d    = state_q;
    breq_d     = breq_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    wait_d     = wait_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        breq_d = 1'b0;
        if (bus.cmd_valid) begin
          if (bus.cmd_len != '0) begin
            addr_d  = bus.cmd_addr;
            rem_d   = bus.cmd_len;
            wait_d  = '0;
            breq_d  = 1'b1;
            state_d = S_REQ;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_REQ: begin
        breq_d = 1'b1;
        if (bus.dma_grant) begin
          wait_d  = '0;
          state_d = S_XFER;
        end else if (wait_q == WAIT_LAST) begin
          // Grant never came: drop the burst and report it.
          breq_d  = 1'b0;
          err_d   = 1'b1;
          rem_d   = '0;
          wait_d  = '0;
          state_d = S_IDLE;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      S_XFER: begin
        breq_d = 1'b1;
        if (bus_rd_w && bus.bus_ack) begin
          rd_data_d  = bus.bus_rdata;
          rd_valid_d = 1'b1;
          addr_d     = addr_q + 1'b1;
          rem_d      = rem_q - 1'b1;
          // Final beat wins over a simultaneous grant drop.
          if (rem_q == LEN_W'(1)) begin
            breq_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_REL;
          end
        end else if (!bus.dma_grant) begin
          wait_d  = '0;
          state_d = S_REQ;
        end
      end
      S_REL: begin
        breq_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        breq_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      breq_q     <= 1'b0;
      addr_q     <= '0;
      rem_q      <= '0;
      wait_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      breq_q     <= breq_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      wait_q     <= wait_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_dma_bus_requester.sv
// Bench for dma_bus_requester: an arbiter/memory model drives grant and ack, the
// observed read stream is compared with addresses and data derived from the command.
module tb_dma_bus_requester;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 8;
  localparam int GT     = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dma_bus_requester_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bif ();

  dma_bus_requester #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .GRANT_TIMEOUT(GT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bif)
  );

  // Memory returns address xor a per-test key.
  logic [15:0] key;
  assign bif.bus_rdata = bif.bus_addr ^ key;

  int total = 0;
  int bad = 0;

  logic [15:0] obs_addr[$];
  logic [15:0] obs_data[$];
  int done_cnt, err_cnt, breq_cycles, done_at, err_at, ready_after;
  int breq_low_mid, rd_no_grant, breq_after_last, done_with_last, timed_out;
  logic snap_breq, snap_rv, snap_done, snap_err;
  logic [15:0] snap_addr, snap_rdata;

  task automatic run_burst(input logic [15:0] a, input int len, input int gdelay,
                           input int drop_beat, input int drop_cycles,
                           input bit rand_ack, input int rst_beat);
    int drop_left, tail, beats;
    bit drop_done, last_prev, started, finished;
    obs_addr.delete(); obs_data.delete();
    done_cnt = 0; err_cnt = 0; breq_cycles = 0; done_at = -1; err_at = -1;
    ready_after = -1; breq_low_mid = 0; rd_no_grant = 0; breq_after_last = -1;
    done_with_last = 0; timed_out = 0;
    drop_left = 0; tail = 0; beats = 0; drop_done = 0; last_prev = 0;
    started = 0; finished = 0;
    @(negedge clk);
    bif.cmd_valid = 1'b1; bif.cmd_addr = a; bif.cmd_len = LEN_W'(len);
    @(negedge clk);
    bif.cmd_valid = 1'b0;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      if (last_prev) begin
        breq_after_last = int'(bif.dma_breq);
        done_with_last  = int'(bif.done && bif.rd_valid);
      end
      if (bif.rd_valid) obs_data.push_back(bif.rd_data);
      if (bif.done) begin done_cnt++; if (done_at < 0) done_at = cyc; end
      if (bif.err) begin err_cnt++; err_at = cyc; ready_after = int'(bif.cmd_ready); end
      if (bif.dma_breq) begin started = 1; breq_cycles++; end
      else if (started && beats < len && done_cnt == 0 && err_cnt == 0) breq_low_mid++;
      if (!drop_done && drop_beat > 0 && beats == drop_beat) begin
        drop_left = drop_cycles; drop_done = 1;
      end
      bif.dma_grant = bif.dma_breq && (breq_cycles > gdelay) && (drop_left == 0);
      if (drop_left > 0) drop_left--;
      bif.bus_ack = rand_ack ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      last_prev = 0;
      if (bif.bus_rd && !bif.dma_grant) rd_no_grant++;
      if (bif.bus_rd && bif.bus_ack) begin
        obs_addr.push_back(bif.bus_addr);
        beats++;
        if (beats == len) last_prev = 1;
        if (rst_beat > 0 && beats == rst_beat) begin
          reset = 1'b1;
          #1;
          snap_breq = bif.dma_breq; snap_rv = bif.rd_valid; snap_done = bif.done;
          snap_err = bif.err; snap_addr = bif.bus_addr; snap_rdata = bif.rd_data;
          bif.dma_grant = 1'b0; bif.bus_ack = 1'b0;
          return;
        end
      end
      if (done_cnt > 0 || err_cnt > 0) tail++;
      if (tail >= 3) begin finished = 1; break; end
      @(negedge clk);
    end
    if (!finished) timed_out = 1;
    bif.dma_grant = 1'b0; bif.bus_ack = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if (bif.dma_breq !== 1'b0) begin bad++; $display("FAIL reset_breq got=%b exp=0", bif.dma_breq); end
    total++; if (bif.bus_addr !== 16'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0000", bif.bus_addr); end
    total++; if ({bif.rd_valid, bif.done, bif.err} !== 3'b000) begin bad++; $display("FAIL reset_pulses got=%b exp=000", {bif.rd_valid, bif.done, bif.err}); end
    total++; if (bif.rd_data !== 16'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0000", bif.rd_data); end
    reset = 1'b0;
    #1;
    total++; if (bif.cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", bif.cmd_ready); end
  endtask

  task automatic test_basic();
    logic [15:0] got;
    key = 16'($urandom);
    run_burst(16'h0100, 4, 2, -1, 0, 1'b0, -1);
    total++; if (timed_out != 0) begin bad++; $display("FAIL basic_timeout got=%0d exp=0", timed_out); end
    total++; if (obs_addr.size() != 4 || obs_data.size() != 4) begin bad++; $display("FAIL basic_count got=%0d/%0d exp=4/4", obs_addr.size(), obs_data.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < obs_addr.size()) ? obs_addr[i] : 16'hxxxx;
      total++; if (got !== 16'(16'h0100 + i)) begin bad++; $display("FAIL basic_addr%0d got=%h exp=%h", i, got, 16'(16'h0100 + i)); end
      got = (i < obs_data.size()) ? obs_data[i] : 16'hxxxx;
      total++; if (got !== (16'(16'h0100 + i) ^ key)) begin bad++; $display("FAIL basic_data%0d got=%h exp=%h", i, got, 16'(16'h0100 + i) ^ key); end
    end
    total++; if (done_cnt != 1 || err_cnt != 0) begin bad++; $display("FAIL basic_done got=%0d/%0d exp=1/0", done_cnt, err_cnt); end
    total++; if (breq_after_last != 0) begin bad++; $display("FAIL basic_breq_release got=%0d exp=0", breq_after_last); end
    total++; if (done_with_last != 1) begin bad++; $display("FAIL basic_done_with_last got=%0d exp=1", done_with_last); end
  endtask

  task automatic test_grant_drop();
    logic [15:0] got;
    key = 16'($urandom);
    run_burst(16'h0100, 3, 1, 1, 5, 1'b0, -1);
    total++; if (timed_out != 0) begin bad++; $display("FAIL drop_timeout got=%0d exp=0", timed_out); end
    total++; if (obs_data.size() != 3) begin bad++; $display("FAIL drop_count got=%0d exp=3", obs_data.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (i < obs_addr.size()) ? obs_addr[i] : 16'hxxxx;
      total++; if (got !== 16'(16'h0100 + i)) begin bad++; $display("FAIL drop_addr%0d got=%h exp=%h", i, got, 16'(16'h0100 + i)); end
      got = (i < obs_data.size()) ? obs_data[i] : 16'hxxxx;
      total++; if (got !== (16'(16'h0100 + i) ^ key)) begin bad++; $display("FAIL drop_data%0d got=%h exp=%h", i, got, 16'(16'h0100 + i) ^ key); end
    end
    total++; if (rd_no_grant != 0) begin bad++; $display("FAIL drop_rd_in_gap got=%0d exp=0", rd_no_grant); end
    total++; if (breq_low_mid != 0) begin bad++; $display("FAIL drop_breq_held got=%0d exp=0", breq_low_mid); end
    total++; if (breq_cycles < 3 + 5) begin bad++; $display("FAIL drop_gap_len got=%0d exp>=8", breq_cycles); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL drop_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_timeout();
    run_burst(16'h1234, 5, 100000, -1, 0, 1'b0, -1);
    total++; if (err_cnt != 1) begin bad++; $display("FAIL tmo_err got=%0d exp=1", err_cnt); end
    total++; if (breq_cycles != GT) begin bad++; $display("FAIL tmo_breq_cycles got=%0d exp=%0d", breq_cycles, GT); end
    total++; if (err_at != GT + 1) begin bad++; $display("FAIL tmo_err_cycle got=%0d exp=%0d", err_at, GT + 1); end
    total++; if (obs_data.size() != 0 || done_cnt != 0) begin bad++; $display("FAIL tmo_no_data got=%0d/%0d exp=0/0", obs_data.size(), done_cnt); end
    total++; if (ready_after != 1) begin bad++; $display("FAIL tmo_ready got=%0d exp=1", ready_after); end
  endtask

  task automatic test_wrap();
    logic [15:0] got;
    key = 16'($urandom);
    run_burst(16'hFFFE, 3, 0, -1, 0, 1'b1, -1);
    total++; if (obs_data.size() != 3 || done_cnt != 1) begin bad++; $display("FAIL wrap_count got=%0d/%0d exp=3/1", obs_data.size(), done_cnt); end
    for (int i = 0; i < 3; i++) begin
      got = (i < obs_addr.size()) ? obs_addr[i] : 16'hxxxx;
      total++; if (got !== 16'(16'hFFFE + i)) begin bad++; $display("FAIL wrap_addr%0d got=%h exp=%h", i, got, 16'(16'hFFFE + i)); end
      got = (i < obs_data.size()) ? obs_data[i] : 16'hxxxx;
      total++; if (got !== (16'(16'hFFFE + i) ^ key)) begin bad++; $display("FAIL wrap_data%0d got=%h exp=%h", i, got, 16'(16'hFFFE + i) ^ key); end
    end
  endtask

  task automatic test_reset_mid();
    int stray;
    logic [15:0] got;
    key = 16'($urandom);
    run_burst(16'h0200, 4, 0, -1, 0, 1'b0, 2);
    total++; if (snap_breq !== 1'b0) begin bad++; $display("FAIL rstmid_breq got=%b exp=0", snap_breq); end
    total++; if ({snap_rv, snap_done, snap_err} !== 3'b000) begin bad++; $display("FAIL rstmid_pulses got=%b exp=000", {snap_rv, snap_done, snap_err}); end
    total++; if (snap_addr !== 16'h0 || snap_rdata !== 16'h0) begin bad++; $display("FAIL rstmid_regs got=%h/%h exp=0000/0000", snap_addr, snap_rdata); end
    @(negedge clk);
    reset = 1'b0;
    stray = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bif.done || bif.err || bif.dma_breq) stray++;
    end
    total++; if (stray != 0) begin bad++; $display("FAIL rstmid_stray got=%0d exp=0", stray); end
    run_burst(16'h0300, 2, 1, -1, 0, 1'b1, -1);
    total++; if (obs_data.size() != 2 || done_cnt != 1) begin bad++; $display("FAIL rstmid_after got=%0d/%0d exp=2/1", obs_data.size(), done_cnt); end
    got = (obs_data.size() > 1) ? obs_data[1] : 16'hxxxx;
    total++; if (got !== (16'h0301 ^ key)) begin bad++; $display("FAIL rstmid_after_data got=%h exp=%h", got, 16'h0301 ^ key); end
  endtask

  task automatic test_zero_len();
    run_burst(16'h4000, 0, 0, -1, 0, 1'b0, -1);
    total++; if (done_cnt != 1 || done_at != 1) begin bad++; $display("FAIL zero_done got=%0d@%0d exp=1@1", done_cnt, done_at); end
    total++; if (breq_cycles != 0) begin bad++; $display("FAIL zero_breq got=%0d exp=0", breq_cycles); end
    total++; if (obs_data.size() != 0 || err_cnt != 0) begin bad++; $display("FAIL zero_data got=%0d/%0d exp=0/0", obs_data.size(), err_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a, got;
    int len;
    for (int n = 0; n < 6; n++) begin
      key = 16'($urandom);
      a = 16'($urandom);
      len = $urandom_range(1, 10);
      run_burst(a, len, $urandom_range(0, 3), $urandom_range(0, len - 1),
                $urandom_range(1, 4), 1'b1, -1);
      total++; if (obs_data.size() != len || done_cnt != 1 || err_cnt != 0 || timed_out != 0)
        begin bad++; $display("FAIL b2b%0d_summary got=%0d/%0d/%0d/%0d exp=%0d/1/0/0", n, obs_data.size(), done_cnt, err_cnt, timed_out, len); end
      for (int i = 0; i < len; i++) begin
        got = (i < obs_data.size()) ? obs_data[i] : 16'hxxxx;
        total++; if (got !== (16'(a + i) ^ key)) begin bad++; $display("FAIL b2b%0d_data%0d got=%h exp=%h", n, i, got, 16'(a + i) ^ key); end
      end
      total++; if (rd_no_grant != 0 || breq_low_mid != 0) begin bad++; $display("FAIL b2b%0d_bus got=%0d/%0d exp=0/0", n, rd_no_grant, breq_low_mid); end
    end
  endtask

  initial begin
    bif.cmd_valid = 1'b0; bif.cmd_addr = '0; bif.cmd_len = '0;
    bif.dma_grant = 1'b0; bif.bus_ack = 1'b0;
    key = 16'h5A3C;
    test_reset();
    test_basic();
    test_grant_drop();
    test_timeout();
    test_wrap();
    test_reset_mid();
    test_zero_len();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
